// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: mode encoding and one-hot helper shared by decoder_scan.
package decoder_scan_pkg;
    typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
    localparam int MAX_N = 5;
    localparam int MAX_M = 1 << MAX_N;
    function automatic logic [MAX_M-1:0] onehot(input logic [MAX_N-1:0] sel);
        return {{(MAX_M-1){1'b0}}, 1'b1} << sel;
    endfunction
endpackage

// File: rtl/decoder_scan_tick_gen.sv
// tick_gen: prescaler counting 0..DIV-1; tick marks the wrapping edge, clr restarts at 0.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && !clr && cnt_q == 16'(DIV - 1);
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 16'd1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with direct and prescaled autonomous scan modes.
// Define DECODER_SCAN_MASK_EN to add a mask input that skips channels while scanning.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int N   = 2,
    parameter int DIV = 4,
    localparam int M  = 1 << N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic         mode,
    input  logic [N-1:0] w,
    input  logic         load,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [M-1:0] mask,
`endif
    output logic [M-1:0] y,
    output logic [N-1:0] idx,
    output logic         frame
);
    logic [M-1:0] y_q, y_d;
    logic [N-1:0] idx_q, idx_d, nxt;
    logic         frame_q, frame_d, mode_q, mode_v_q;
    logic         scan_en, ld, clr, tick, wrap, none;

    assign scan_en = E && mode == MODE_SCAN;
    assign ld      = scan_en && load;
    // mode_v_q keeps the first edge after reset from counting as a mode change
    assign clr     = ld || (mode_v_q && mode != mode_q);

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (scan_en),
        .clr  (clr),
        .tick (tick)
    );

`ifdef DECODER_SCAN_MASK_EN
    logic         found;
    logic [N-1:0] cand;
    always_comb begin
        nxt   = idx_q;
        found = 1'b0;
        cand  = idx_q;
        for (int k = 1; k <= M; k++) begin
            cand = idx_q + N'(k);
            if (!found && !mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        none = &mask;
        wrap = found && nxt <= idx_q;
    end
`else
    assign nxt  = idx_q + N'(1);
    assign none = 1'b0;
    assign wrap = &idx_q;
`endif

    always_comb begin
        idx_d   = idx_q;
        y_d     = '0;
        frame_d = 1'b0;
        if (E && mode == MODE_DIRECT) y_d = M'(onehot(MAX_N'(w)));
        else if (ld) begin
            idx_d = w;
            y_d   = M'(onehot(MAX_N'(w)));
        end else if (scan_en && !none) begin
            idx_d   = tick ? nxt : idx_q;
            y_d     = M'(onehot(MAX_N'(idx_d)));
            frame_d = tick && wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y_q      <= '0;
            idx_q    <= '0;
            frame_q  <= 1'b0;
            mode_q   <= MODE_DIRECT;
            mode_v_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            mode_q   <= mode;
            mode_v_q <= 1'b1;
        end

    assign y     = y_q;
    assign idx   = idx_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed checks of decoder_scan (N=2, DIV=3 plus a DIV=1 instance).
module tb_decoder_scan;
    logic       clk, rst_n, E, mode, load;
    logic [1:0] w;
    logic [3:0] y, y1;
    logic [1:0] idx, idx1;
    logic       frame, frame1;
    int         checks = 0;
    int         errors = 0;
`ifdef DECODER_SCAN_MASK_EN
    logic [3:0] mask = 4'b0000;
`endif

    decoder_scan #(.N(2), .DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .w(w), .load(load),
`ifdef DECODER_SCAN_MASK_EN
        .mask(mask),
`endif
        .y(y), .idx(idx), .frame(frame)
    );

    decoder_scan #(.N(2), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .w(w), .load(load),
`ifdef DECODER_SCAN_MASK_EN
        .mask(mask),
`endif
        .y(y1), .idx(idx1), .frame(frame1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; E = 1'b0; mode = 1'b0; load = 1'b0; w = 2'd0;
        cyc(); cyc();
        checks++;
        if (y !== 4'b0000 || idx !== 2'd0 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset: y=%b idx=%0d frame=%b, want 0000/0/0", y, idx, frame);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_disabled();
        E = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 2'(i);
            cyc();
            checks++;
            if (y !== 4'b0000) begin
                errors++;
                $display("FAIL disabled w=%0d: y=%b, want 0000", i, y);
            end
        end
    endtask

    task automatic test_direct();
        E = 1'b1; mode = 1'b0; load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 2'(i);
            cyc();
            checks++;
            if (y !== (4'b0001 << i) || idx !== 2'd0) begin
                errors++;
                $display("FAIL direct w=%0d: y=%b idx=%0d, want y=%b idx=0", i, y, idx, 4'b0001 << i);
            end
        end
        load = 1'b0; w = 2'd0;
    endtask

    task automatic test_scan();
        E = 1'b0; mode = 1'b1;
        cyc();
        checks++;
        if (y !== 4'b0000 || idx !== 2'd0) begin
            errors++;
            $display("FAIL scan_entry: y=%b idx=%0d, want 0000/0", y, idx);
        end
        E = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if (idx !== 2'((k / 3) % 4) || y !== (4'b0001 << ((k / 3) % 4)) || frame !== (k == 12)) begin
                errors++;
                $display("FAIL scan k=%0d: idx=%0d y=%b frame=%b, want idx=%0d y=%b frame=%b",
                         k, idx, y, frame, (k / 3) % 4, 4'b0001 << ((k / 3) % 4), k == 12);
            end
        end
    endtask

    task automatic test_load();
        cyc(); cyc();
        checks++;
        if (idx !== 2'd0) begin
            errors++;
            $display("FAIL load_pre: idx=%0d, want 0", idx);
        end
        load = 1'b1; w = 2'd2;
        cyc();
        load = 1'b0; w = 2'd0;
        checks++;
        if (idx !== 2'd2 || y !== 4'b0100 || frame !== 1'b0) begin
            errors++;
            $display("FAIL load: idx=%0d y=%b frame=%b, want 2/0100/0", idx, y, frame);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (idx !== (k < 3 ? 2'd2 : 2'd3) || frame !== 1'b0) begin
                errors++;
                $display("FAIL load_after k=%0d: idx=%0d frame=%b, want idx=%0d frame=0", k, idx, frame, k < 3 ? 2 : 3);
            end
        end
    endtask

    task automatic test_freeze();
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (idx !== (k < 3 ? 2'd3 : k < 6 ? 2'd0 : 2'd1) || frame !== (k == 3)) begin
                errors++;
                $display("FAIL freeze_pre k=%0d: idx=%0d frame=%b", k, idx, frame);
            end
        end
        E = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            checks++;
            if (y !== 4'b0000 || idx !== 2'd1 || frame !== 1'b0) begin
                errors++;
                $display("FAIL freeze k=%0d: y=%b idx=%0d frame=%b, want 0000/1/0", k, y, idx, frame);
            end
        end
        E = 1'b1;
        cyc();
        checks++;
        if (idx !== 2'd1 || y !== 4'b0010) begin
            errors++;
            $display("FAIL resume1: idx=%0d y=%b, want 1/0010", idx, y);
        end
        cyc();
        checks++;
        if (idx !== 2'd2 || y !== 4'b0100) begin
            errors++;
            $display("FAIL resume2: idx=%0d y=%b, want 2/0100", idx, y);
        end
    endtask

    task automatic test_async_reset();
        cyc(); cyc(); cyc();
        checks++;
        if (idx !== 2'd3) begin
            errors++;
            $display("FAIL areset_pre: idx=%0d, want 3", idx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 4'b0000 || idx !== 2'd0 || frame !== 1'b0 || y1 !== 4'b0000 || idx1 !== 2'd0) begin
            errors++;
            $display("FAIL areset: y=%b idx=%0d frame=%b y1=%b idx1=%0d, want all 0", y, idx, frame, y1, idx1);
        end
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (idx !== 2'((k / 3) % 4) || frame !== 1'b0) begin
                errors++;
                $display("FAIL restart k=%0d: idx=%0d frame=%b, want idx=%0d frame=0", k, idx, frame, (k / 3) % 4);
            end
            checks++;
            if (idx1 !== 2'(k % 4) || y1 !== (4'b0001 << (k % 4)) || frame1 !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL div1 k=%0d: idx=%0d y=%b frame=%b, want idx=%0d y=%b frame=%b",
                         k, idx1, y1, frame1, k % 4, 4'b0001 << (k % 4), k % 4 == 0);
            end
        end
    endtask

`ifdef DECODER_SCAN_MASK_EN
    task automatic test_mask();
        rst_n = 1'b0;
        mask = 4'b0110;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if (idx !== (((k / 3) % 2) == 1 ? 2'd3 : 2'd0) || frame !== (k == 6 || k == 12)) begin
                errors++;
                $display("FAIL mask k=%0d: idx=%0d frame=%b, want idx=%0d frame=%b",
                         k, idx, frame, ((k / 3) % 2) == 1 ? 3 : 0, k == 6 || k == 12);
            end
        end
        mask = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (y !== 4'b0000 || idx !== 2'd0 || frame !== 1'b0) begin
                errors++;
                $display("FAIL mask_all k=%0d: y=%b idx=%0d frame=%b, want 0000/0/0", k, y, idx, frame);
            end
        end
        mask = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_disabled();
        test_direct();
        test_scan();
        test_load();
        test_freeze();
        test_async_reset();
`ifdef DECODER_SCAN_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter: N, 2, select width; channel count M = 2^N; legal range 1..5.
REQ-002 Parameter: DIV, 4, clock cycles per scan step; legal range 1..65535.
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: E  input  1  enable; low forces y to zero and freezes scan state.
REQ-006 Port: mode  input  1  0 = direct decode of w, 1 = autonomous scan.
REQ-007 Port: w  input  N  direct-mode select; scan-mode load value.
REQ-008 Port: load  input  1  scan mode only: load scan index from w.
REQ-009 Port: y  output  M  registered one-hot channel output.
REQ-010 Port: idx  output  N  registered current scan index.
REQ-011 Port: frame  output  1  one-cycle pulse on scan wrap M-1 -> 0.

Function
REQ-012 Direct mode, E=1: y SHALL equal 1<<w one clock after w is sampled; idx and prescaler hold.
REQ-013 Any mode, E=0: y SHALL be 0 on the next edge; idx, prescaler and frame hold/clear (frame = 0).
REQ-014 Scan mode, E=1: prescaler counts 0..DIV-1, wrapping to 0; the edge on which it wraps is a step.
REQ-015 On a step, idx SHALL advance to (idx+1) mod M; y SHALL show 1<<idx for the new idx on the same edge.
REQ-016 DIV=1: a step occurs every enabled cycle.
REQ-017 frame SHALL pulse high for exactly one cycle on the step where idx goes M-1 -> 0; low otherwise.
REQ-018 load=1 in scan mode with E=1: idx <= w, prescaler <= 0, y <= 1<<w; load overrides a coincident step; no frame pulse.
REQ-019 load SHALL be ignored in direct mode or when E=0.
REQ-020 Any change of mode SHALL clear the prescaler on that edge; idx retained.
REQ-021 y SHALL never have more than one bit set.

Reset
REQ-022 rst_n low SHALL asynchronously force y=0, idx=0, prescaler=0, frame=0.
REQ-023 Deassertion mid-scan SHALL resume from idx=0, prescaler=0; first step occurs DIV enabled cycles later.

Configuration
REQ-024 Macro DECODER_SCAN_MASK_EN defined: extra input port mask [M-1:0]; a 1 bit marks a channel skipped in scan mode.
REQ-025 With the macro: a step SHALL move idx to the next unmasked index in ascending cyclic order within one cycle; frame pulses when that move wraps past M-1.
REQ-026 With the macro: all channels masked -> y=0, idx holds, no frame; direct mode and load ignore mask.
REQ-027 Without the macro: no mask port; all M channels scanned in order.

Structure
REQ-028 Package decoder_scan_pkg SHALL hold mode constants MODE_DIRECT/MODE_SCAN and the one-hot encode function.
REQ-029 Prescaler SHALL be a sub-module tick_gen (param DIV; inputs clk, rst_n, en, clr; output tick).

Verification (N=2, DIV=3 unless stated)
REQ-030 Reset then E=0, w sweeps 00..11 -> y=0000 throughout; E=1, w sweeps 00..11 in direct mode -> y=0001,0010,0100,1000, each one cycle after w.
REQ-031 Scan mode, E=1 for 12 cycles -> idx 0,1,2,3 each held 3 cycles; frame pulses once at 3 -> 0; y one-hot matching idx.
REQ-032 Scan mode, load=1 with w=10 on a step edge -> idx=2, y=0100, next step 3 cycles later, no frame.
REQ-033 Scan mode, E dropped for 5 cycles at idx=1 mid-count -> y=0000, idx stays 1, count resumes where frozen.
REQ-034 rst_n pulsed low between edges while idx=3 -> y, idx, frame 0 immediately; DIV=1 rerun shows step every cycle.
REQ-035 With DECODER_SCAN_MASK_EN, mask=0110 -> idx sequence 0,3,0,3 with frame each wrap; mask=1111 -> y=0000, idx holds.
